// File: rtl/lcd_video_pkg.sv
// lcd_video_pkg: shared pixel types, background fetch states and RGB565 to RGB888 expansion
package lcd_video_pkg;
  typedef logic [15:0] rgb565_t;
  typedef logic [23:0] rgb888_t;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} fetch_state_t;
  function automatic rgb888_t expand565(input rgb565_t p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction
endpackage

// File: rtl/line_buffer_dp.sv
// line_buffer_dp: simple dual-port RAM, synchronous read returns old data on a same-address write
module line_buffer_dp #(
  parameter int DEPTH = 720,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/lcd_compositor.sv
// lcd_compositor: tints lit LCD segments over a ping-pong prefetched background line, two-cycle pixel latency
module lcd_compositor
  import lcd_video_pkg::*;
#(
  parameter int          H_ACTIVE  = 720,
  parameter int          V_ACTIVE  = 720,
  parameter logic [23:0] SEG_COLOR = 24'h101810,
  parameter logic [23:0] BG_BASE   = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        segment_en,
  input  logic        vblank_int,
  input  logic        hblank_int,
  input  logic [9:0]  video_x,
  input  logic [9:0]  video_y,
  output logic        bg_rd_req,
  output logic [23:0] bg_rd_addr,
  input  logic        bg_rd_ready,
  input  logic        bg_rd_valid,
  input  logic [15:0] bg_rd_data,
  output logic [23:0] rgb,
  output logic        de,
  output logic        underrun
);
  localparam int AW = $clog2(H_ACTIVE);
  localparam int CW = $clog2(H_ACTIVE + 1);
  fetch_state_t state;
  logic [CW-1:0] issue_cnt, recv_cnt, recv_next;
  logic [9:0] pend_line, trig_line, start_line;
  logic tgt, hb_prev, vb_prev, vb_rise, trig, accept, done, start, we;
  logic sel_q, seg_q, de_q;
  logic [AW-1:0] raddr;
  rgb565_t rd0, rd1;
  rgb888_t bg, blend;
  assign vb_rise = vblank_int & ~vb_prev;
  assign trig = vb_rise | (hblank_int & ~hb_prev & (video_y < 10'(V_ACTIVE - 1)));
  assign trig_line = vb_rise ? '0 : video_y + 10'd1;
  assign accept = bg_rd_req & bg_rd_ready;
  assign recv_next = recv_cnt + CW'(bg_rd_valid);
  assign done = recv_next == CW'(H_ACTIVE);
  // a trigger landing on the final word is a clean completion; drain restarts once nothing is outstanding
  assign start = (state == IDLE && trig) || (state == ISSUE && trig && done) ||
                 (state == DRAIN && issue_cnt == recv_next);
  assign start_line = (state == DRAIN && !trig) ? pend_line : trig_line;
  assign bg_rd_req = state == ISSUE && issue_cnt != CW'(H_ACTIVE);
  assign we = bg_rd_valid && state == ISSUE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      issue_cnt <= '0;
      recv_cnt <= '0;
      pend_line <= '0;
      tgt <= 1'b0;
      bg_rd_addr <= BG_BASE;
      underrun <= 1'b0;
      hb_prev <= 1'b0;
      vb_prev <= 1'b0;
    end else begin
      hb_prev <= hblank_int;
      vb_prev <= vblank_int;
      if (start) begin
        state <= ISSUE;
        issue_cnt <= '0;
        recv_cnt <= '0;
        tgt <= start_line[0];
        bg_rd_addr <= BG_BASE + 24'(start_line) * 24'(H_ACTIVE);
      end else if (state != IDLE) begin
        issue_cnt <= issue_cnt + CW'(accept);
        recv_cnt <= recv_next;
        if (accept) bg_rd_addr <= bg_rd_addr + 24'd1;
        if (trig) pend_line <= trig_line;
        if (state == ISSUE && trig) begin
          state <= DRAIN;
          underrun <= 1'b1;
        end else if (state == ISSUE && done) state <= IDLE;
      end
    end
  end
  assign raddr = video_x >= 10'(H_ACTIVE) ? AW'(H_ACTIVE - 1) : AW'(video_x);
  line_buffer_dp #(.DEPTH(H_ACTIVE), .WIDTH(16)) u_buf0 (
    .clk(clk), .we(we & ~tgt), .waddr(AW'(recv_cnt)), .wdata(bg_rd_data), .raddr(raddr), .rdata(rd0)
  );
  line_buffer_dp #(.DEPTH(H_ACTIVE), .WIDTH(16)) u_buf1 (
    .clk(clk), .we(we & tgt), .waddr(AW'(recv_cnt)), .wdata(bg_rd_data), .raddr(raddr), .rdata(rd1)
  );
  assign bg = expand565(sel_q ? rd1 : rd0);
  for (genvar c = 0; c < 3; c++) begin : g_blend
    assign blend[8*c +: 8] = 8'(({2'b0, bg[8*c +: 8]} + 10'(SEG_COLOR[8*c +: 8]) * 10'd3) >> 2);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= 1'b0;
      seg_q <= 1'b0;
      de_q <= 1'b0;
      rgb <= '0;
      de <= 1'b0;
    end else begin
      sel_q <= video_y[0];
      seg_q <= segment_en;
      de_q <= ~hblank_int & ~vblank_int;
      rgb <= seg_q ? blend : bg;
      de <= de_q;
    end
  end
endmodule

// File: tb/tb_lcd_compositor.sv
// tb_lcd_compositor: directed checks of background prefetch, stalls, underrun, reset and pixel blending
module tb_lcd_compositor;
  logic clk = 0, reset = 1, segment_en = 0, vblank_int = 0, hblank_int = 0;
  logic [9:0] video_x = 0, video_y = 0;
  logic bg_rd_req, bg_rd_ready = 0, bg_rd_valid = 0, de, underrun;
  logic [23:0] bg_rd_addr, rgb;
  logic [15:0] bg_rd_data = 0;
  int checks = 0, errors = 0;
  logic mem_en = 0, const_mode = 0, pv = 0, fv = 0, stable;
  logic [15:0] pd = 0, fd = 0;
  logic [23:0] snap;
  logic [23:0] acc_q[$];

  lcd_compositor dut (
    .clk(clk), .reset(reset), .segment_en(segment_en), .vblank_int(vblank_int),
    .hblank_int(hblank_int), .video_x(video_x), .video_y(video_y),
    .bg_rd_req(bg_rd_req), .bg_rd_addr(bg_rd_addr), .bg_rd_ready(bg_rd_ready),
    .bg_rd_valid(bg_rd_valid), .bg_rd_data(bg_rd_data), .rgb(rgb), .de(de), .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input logic [23:0] a);
    logic [23:0] m;
    m = a * 24'd37;
    return m[15:0] ^ 16'h5A3C;
  endfunction

  function automatic logic [23:0] exp888(input logic [15:0] p);
    logic [7:0] r, g, b;
    r = {p[15:11], 3'b0} | {5'b0, p[15:13]};
    g = {p[10:5], 2'b0} | {6'b0, p[10:9]};
    b = {p[4:0], 3'b0} | {5'b0, p[4:2]};
    return {r, g, b};
  endfunction

  // memory answers one cycle after each accept; when disabled the bench drives valid/data directly
  initial forever begin
    @(negedge clk);
    if (mem_en) begin
      bg_rd_valid = pv;
      bg_rd_data = pd;
      pv = bg_rd_req && bg_rd_ready;
      pd = const_mode ? 16'hF800 : pat(bg_rd_addr);
      if (pv) acc_q.push_back(bg_rd_addr);
    end else begin
      pv = 0;
      bg_rd_valid = fv;
      bg_rd_data = fd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_acc(input int n, input int extra);
    int c = 0;
    while (acc_q.size() < n && c < 5000) begin
      tick();
      c++;
    end
    repeat (extra) tick();
  endtask

  function automatic int seq_err(input logic [23:0] base);
    foreach (acc_q[i]) if (acc_q[i] !== base + 24'(i)) return i;
    return -1;
  endfunction

  task automatic px(input int x, input int y, input logic s);
    video_x = 10'(x);
    video_y = 10'(y);
    segment_en = s;
    tick();
    tick();
  endtask

  initial begin
    repeat (3) tick();
    check("rst_rgb", rgb, 0);
    check("rst_de", de, 0);
    check("rst_req", bg_rd_req, 0);
    check("rst_addr", bg_rd_addr, 0);
    check("rst_underrun", underrun, 0);
    reset = 0;
    bg_rd_ready = 1;
    mem_en = 1;
    tick();
    vblank_int = 1;
    wait_acc(720, 4);
    check("f0_count", acc_q.size(), 720);
    check("f0_seq", seq_err(0), -1);
    check("f0_idle_req", bg_rd_req, 0);
    check("f0_underrun", underrun, 0);
    vblank_int = 0;
    px(0, 0, 0);
    check("f0_px0", rgb, exp888(pat(0)));
    check("f0_de", de, 1);
    px(5, 0, 0);
    check("f0_px5", rgb, exp888(pat(5)));
    px(719, 0, 0);
    check("f0_px719", rgb, exp888(pat(719)));
    px(800, 0, 0);
    check("f0_px_clamp", rgb, exp888(pat(719)));

    const_mode = 1;
    acc_q.delete();
    vblank_int = 1;
    wait_acc(720, 4);
    vblank_int = 0;
    check("red_count", acc_q.size(), 720);
    px(5, 0, 0);
    check("red_bg", rgb, 24'hFF0000);
    px(5, 0, 1);
    check("red_blend", rgb, 24'h4B120C);
    const_mode = 0;

    acc_q.delete();
    video_y = 0;
    segment_en = 0;
    hblank_int = 1;
    tick();
    tick();
    check("hblank_de", de, 0);
    wait_acc(100, 0);
    bg_rd_ready = 0;
    snap = bg_rd_addr;
    stable = 1;
    repeat (10) begin
      tick();
      if (bg_rd_req !== 1 || bg_rd_addr !== snap) stable = 0;
    end
    check("stall_stable", stable, 1);
    check("stall_addr", bg_rd_addr, 820);
    bg_rd_ready = 1;
    hblank_int = 0;
    wait_acc(720, 4);
    check("l1_count", acc_q.size(), 720);
    check("l1_seq", seq_err(720), -1);
    px(0, 1, 0);
    check("l1_px0", rgb, exp888(pat(720)));
    px(100, 1, 0);
    check("l1_px100", rgb, exp888(pat(820)));
    px(719, 1, 0);
    check("l1_px719", rgb, exp888(pat(1439)));

    acc_q.delete();
    hblank_int = 1;
    wait_acc(50, 0);
    bg_rd_ready = 0;
    repeat (5) tick();
    check("pre_underrun", underrun, 0);
    hblank_int = 0;
    tick();
    acc_q.delete();
    video_y = 2;
    hblank_int = 1;
    tick();
    tick();
    check("underrun_set", underrun, 1);
    bg_rd_ready = 1;
    hblank_int = 0;
    wait_acc(720, 4);
    check("l3_count", acc_q.size(), 720);
    check("l3_seq", seq_err(2160), -1);
    check("underrun_sticky", underrun, 1);
    px(0, 3, 0);
    check("l3_px0", rgb, exp888(pat(2160)));
    px(719, 3, 0);
    check("l3_px719", rgb, exp888(pat(2879)));

    acc_q.delete();
    video_y = 0;
    vblank_int = 1;
    wait_acc(720, 4);
    vblank_int = 0;
    check("l0b_count", acc_q.size(), 720);
    const_mode = 1;
    acc_q.delete();
    tick();
    vblank_int = 1;
    wait_acc(300, 0);
    reset = 1;
    mem_en = 0;
    vblank_int = 0;
    tick();
    check("midrst_req", bg_rd_req, 0);
    check("midrst_rgb", rgb, 0);
    check("midrst_underrun", underrun, 0);
    reset = 0;
    bg_rd_ready = 0;
    fd = 16'h07E0;
    repeat (3) begin
      fv = 1;
      tick();
      fv = 0;
      tick();
    end
    check("stray_req", bg_rd_req, 0);
    px(0, 0, 0);
    check("stray_px0", rgb, 24'hFF0000);
    px(500, 0, 0);
    check("stray_px500", rgb, exp888(pat(500)));

    const_mode = 0;
    mem_en = 1;
    bg_rd_ready = 1;
    acc_q.delete();
    video_y = 5;
    hblank_int = 1;
    vblank_int = 1;
    wait_acc(720, 4);
    check("both_count", acc_q.size(), 720);
    check("both_seq", seq_err(0), -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
